// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one byte-level UART transmitter between NUM_REQ byte-stream
//   requesters. Grants are round-robin and locked per packet: the granted
//   requester owns the transmitter until it sends a byte flagged last, or
//   until it leaves req_valid low for TIMEOUT_CYCLES cycles (0 = never).
//
// Parameters
//   NUM_REQ         number of requesters (2..8)
//   TIMEOUT_CYCLES  stall cycles tolerated while locked, 0 disables
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   req_valid      per requester: a byte is presented
//   req_data       per requester byte, requester i at [8i+7:8i]
//   req_last       per requester: presented byte ends the packet
//   req_ready      per requester: presented byte accepted this cycle
//   tx_valid       byte valid towards the UART transmitter
//   tx_data        byte towards the UART transmitter
//   tx_ready       transmitter accepts tx_data
//   busy           a requester holds the lock
//   grant_id       index of the locked requester (meaningful while busy)
//   timeout_pulse  one-cycle pulse when a lock is force-released
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_pulse
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  // One extra bit so rr_ptr + offset can be reduced modulo NUM_REQ.
  localparam int unsigned SW = GW + 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] NREQ_S = SW'(NUM_REQ);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_e;

  state_e         state_q, state_d;
  logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic           pulse_q, pulse_d;
  logic [CW-1:0]  stall_q, stall_d;

  logic           pick_found;
  logic [GW-1:0]  pick_idx;
  logic [SW-1:0]  cand;
  logic           sel_last;
  logic [GW-1:0]  ptr_after;

  // Round-robin search: first requesting index at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + SW'(k);
      if (cand >= NREQ_S) begin
        cand = cand - NREQ_S;
      end
      if (!pick_found && req_valid[cand[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[GW-1:0];
      end
    end
  end

  // Pass-through of the locked requester towards the transmitter.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    sel_last  = 1'b0;
    if (state_q == S_LOCKED) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant_q == GW'(i)) begin
          tx_valid     = req_valid[i];
          tx_data      = req_data[8*i +: 8];
          sel_last     = req_last[i];
          req_ready[i] = tx_ready;
        end
      end
    end
  end

  always_comb begin
    ptr_after = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
  end

  // A transfer takes priority over a timeout that would fire in the same
  // cycle; backpressure cycles neither advance nor clear the stall count.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    pulse_d  = 1'b0;
    stall_d  = stall_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          stall_d = '0;
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (tx_valid && tx_ready) begin
          stall_d = '0;
          if (sel_last) begin
            state_d  = S_IDLE;
            rr_ptr_d = ptr_after;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (stall_q == TO_VAL)) begin
          state_d  = S_IDLE;
          rr_ptr_d = ptr_after;
          pulse_d  = 1'b1;
          stall_d  = '0;
        end else if (!tx_valid && (stall_q != '1)) begin
          stall_d = stall_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      pulse_q  <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      pulse_q  <= pulse_d;
      stall_q  <= stall_d;
    end
  end

  assign busy          = (state_q == S_LOCKED);
  assign grant_id      = grant_q;
  assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned T = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic           busy;
  logic [1:0]     grant_id;
  logic           timeout_pulse;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .grant_id(grant_id),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Per-requester byte queues: bit 8 = last flag.
  logic [8:0] srcq [N][$];
  logic [N-1:0] hold;

  // Reference model state.
  bit          m_locked;
  logic [1:0]  m_owner;
  logic [1:0]  m_ptr;
  int unsigned m_stall;
  bit          m_pulse;

  // Observations of the DUT.
  logic [7:0]  dut_tx[$];
  int unsigned dut_grant[$];
  int unsigned dut_gap[$];
  int unsigned idle_run, pulse_cnt, busy_cnt, rdy_other;
  bit          prev_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    dut_tx.delete(); dut_grant.delete(); dut_gap.delete();
    idle_run = 0; pulse_cnt = 0; busy_cnt = 0; rdy_other = 0; prev_busy = busy;
  endtask

  task automatic drive(input logic tr);
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && !hold[i]) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = srcq[i][0][7:0];
        req_last[i]       = srcq[i][0][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
    tx_ready = tr;
  endtask

  task automatic check_cycle();
    logic [N-1:0] exp_rdy;
    exp_rdy = '0;
    if (m_locked && tx_ready) exp_rdy[m_owner] = 1'b1;
    chk("busy", 32'(busy), 32'(m_locked));
    chk("tx_valid", 32'(tx_valid), 32'(m_locked && req_valid[m_owner]));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    if (m_locked) chk("grant_id", 32'(grant_id), 32'(m_owner));
    if (m_locked && req_valid[m_owner]) chk("tx_data", 32'(tx_data), 32'(req_data[8*m_owner +: 8]));
    if (busy && !prev_busy) begin
      dut_grant.push_back(32'(grant_id));
      dut_gap.push_back(idle_run);
    end
    idle_run = busy ? 0 : idle_run + 1;
    prev_busy = busy;
    if (tx_valid && tx_ready) dut_tx.push_back(tx_data);
    if (timeout_pulse) pulse_cnt++;
    if (busy) busy_cnt++;
    if (busy) begin
      if ((req_ready & ~(N'(1) << grant_id)) != '0) rdy_other++;
    end else if (req_ready != '0) begin
      rdy_other++;
    end
  endtask

  // Advance the model across one rising edge using the inputs held this cycle.
  task automatic step();
    logic [N-1:0] rv, rl;
    logic tr;
    bit found;
    int idx;
    rv = req_valid; rl = req_last; tr = tx_ready;
    @(posedge clk);
    m_pulse = 0;
    if (!m_locked) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (int'(m_ptr) + k) % N;
        if (!found && rv[idx]) begin
          found = 1;
          m_owner = 2'(idx);
        end
      end
      if (found) begin
        m_locked = 1;
        m_stall = 0;
      end
    end else if (rv[m_owner] && tr) begin
      void'(srcq[m_owner].pop_front());
      m_stall = 0;
      if (rl[m_owner]) begin
        m_locked = 0;
        m_ptr = 2'((int'(m_owner) + 1) % N);
      end
    end else if (m_stall >= T) begin
      m_locked = 0;
      m_ptr = 2'((int'(m_owner) + 1) % N);
      m_pulse = 1;
      m_stall = 0;
    end else if (!rv[m_owner]) begin
      m_stall++;
    end
    @(negedge clk);
  endtask

  task automatic cycle(input logic tr);
    drive(tr);
    #1;
    check_cycle();
    step();
  endtask

  int unsigned len;

  initial begin
    reset_n = 1'b0; hold = '0; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
    m_locked = 0; m_owner = '0; m_ptr = '0; m_stall = 0; m_pulse = 0;
    prev_busy = 0;
    clear_logs();
    @(negedge clk);

    // Reset: requests and tx_ready present, nothing may respond.
    srcq[1].push_back(9'h1AA);
    repeat (2) begin
      drive(1'b1);
      #1;
      check_cycle();
      @(negedge clk);
    end
    srcq[1].delete();
    drive(1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single packet "OK" from requester 2, tx_ready every 10th cycle.
    clear_logs();
    srcq[2].push_back(9'h04F);
    srcq[2].push_back(9'h14B);
    for (int c = 0; c < 30; c++) cycle(c % 10 == 9);
    chk("ok_ngrant", dut_grant.size(), 1);
    chk("ok_grant", dut_grant[0], 2);
    chk("ok_idle_before", dut_gap[0], 1);
    chk("ok_ntx", dut_tx.size(), 2);
    chk("ok_byte0", 32'(dut_tx[0]), 32'h4F);
    chk("ok_byte1", 32'(dut_tx[1]), 32'h4B);
    chk("ok_busy_end", 32'(busy), 0);

    // Timeout: requester 3 sends one non-last byte then goes silent.
    clear_logs();
    srcq[3].push_back(9'h033);
    srcq[0].push_back(9'h0A0);
    srcq[0].push_back(9'h1A1);
    repeat (40) cycle(1'b1);
    chk("to_ngrant", dut_grant.size(), 2);
    chk("to_grant0", dut_grant[0], 3);
    chk("to_grant1", dut_grant[1], 0);
    chk("to_gap1", dut_gap[1], 1);
    chk("to_pulses", pulse_cnt, 1);
    chk("to_busy_cycles", busy_cnt, T + 2 + 2);
    chk("to_tx2", 32'(dut_tx[2]), 32'hA1);

    // Lock hold: requester 1 waits while requester 0 sends 3 bytes.
    clear_logs();
    srcq[0].push_back(9'h0B0);
    srcq[0].push_back(9'h0B1);
    srcq[0].push_back(9'h1B2);
    cycle(1'b1);
    srcq[1].push_back(9'h1C1);
    for (int c = 0; c < 20; c++) cycle(c % 2 == 0);
    chk("lh_ngrant", dut_grant.size(), 2);
    chk("lh_grant0", dut_grant[0], 0);
    chk("lh_grant1", dut_grant[1], 1);
    chk("lh_rdy_other", rdy_other, 0);
    chk("lh_ntx", dut_tx.size(), 4);
    chk("lh_tx2", 32'(dut_tx[2]), 32'hB2);
    chk("lh_tx3", 32'(dut_tx[3]), 32'hC1);

    // Backpressure for 100 cycles, then last byte on the timeout cycle.
    clear_logs();
    srcq[1].push_back(9'h0D0);
    srcq[1].push_back(9'h1D1);
    repeat (101) cycle(1'b0);
    cycle(1'b1);
    hold[1] = 1'b1;
    repeat (T) cycle(1'b1);
    hold[1] = 1'b0;
    cycle(1'b1);
    repeat (3) cycle(1'b1);
    chk("bp_pulses", pulse_cnt, 0);
    chk("bp_busy_cycles", busy_cnt, 100 + 1 + T + 1);
    chk("bp_ntx", dut_tx.size(), 2);
    chk("bp_tx1", 32'(dut_tx[1]), 32'hD1);
    chk("bp_busy_end", 32'(busy), 0);

    // Reset during byte 2 of a 5-byte packet.
    clear_logs();
    for (int b = 0; b < 5; b++) srcq[2].push_back({(b == 4), 8'(8'hE0 + b)});
    cycle(1'b1);
    cycle(1'b1);
    drive(1'b1);
    #1;
    check_cycle();
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    m_locked = 0; m_ptr = '0; m_stall = 0; m_pulse = 0;
    srcq[2].delete();
    @(negedge clk);
    drive(1'b1);
    reset_n = 1'b1;
    clear_logs();
    srcq[1].push_back(9'h1F1);
    srcq[3].push_back(9'h1F3);
    repeat (8) cycle(1'b1);
    chk("rst_ngrant", dut_grant.size(), 2);
    chk("rst_grant0", dut_grant[0], 1);
    chk("rst_grant1", dut_grant[1], 3);

    // Round robin: everyone requests 1-byte packets continuously.
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) srcq[i].push_back(9'h100 | 9'(i << 4) | 9'(r));
    repeat (24) cycle(1'b1);
    chk("rr_ngrant", dut_grant.size(), 8);
    for (int g = 0; g < 8; g++) begin
      chk("rr_grant", dut_grant[g], g % N);
      chk("rr_gap", dut_gap[g], 1);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() == 0 && $urandom_range(7) == 0) begin
          len = $urandom_range(4, 1);
          for (int b = 0; b < int'(len); b++) srcq[i].push_back({(b == int'(len) - 1), 8'($urandom)});
        end
        if ($urandom_range(29) == 0) hold[i] = ~hold[i];
      end
      cycle($urandom_range(2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
